// File: rtl/shift_normalizer_pkg.sv
// ============================================================================
// shift_normalizer_pkg : FSM states and direction encoding for shift_normalizer
// Rev 1.0
// ============================================================================
`default_nettype none

package shift_normalizer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Same sr encoding as the variable shifter, so shamt can be fed straight back
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_normalizer.sv
// ============================================================================
// shift_normalizer : iterative one-bit-per-cycle normalizer, start/busy/done
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_normalizer #(
  parameter  int WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             sr,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic [SHW-1:0]   shamt,
  output logic             zero
);

  import shift_normalizer_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_count;
  logic             r_sr;

  logic             w_target;
  logic [WIDTH-1:0] w_next;

  // Bit that must end up set, and the work word moved one step toward it
  assign w_target = (r_sr == DIR_RIGHT) ? r_work[0] : r_work[WIDTH-1];
  assign w_next   = (r_sr == DIR_RIGHT) ? {1'b0, r_work[WIDTH-1:1]}
                                        : {r_work[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_count  <= '0;
      r_sr     <= DIR_LEFT;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      shamt    <= '0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (data_in == '0) begin
              // Nothing to normalize: finish at the accepting edge
              done     <= 1'b1;
              zero     <= 1'b1;
              shamt    <= '0;
              data_out <= '0;
            end else begin
              r_work  <= data_in;
              r_sr    <= sr;
              r_count <= '0;
              busy    <= 1'b1;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (w_target) begin
            data_out <= r_work;
            shamt    <= r_count;
            zero     <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_work  <= w_next;
            r_count <= r_count + SHW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
